siphash_msg_ctrl: RTL and testbench

//  Message sequencer for the siphash core (SipHash-c-d, cmd = {opcode[3:0], data[63:0]}, we/busy).

---
 rtl/siphash_msg_ctrl_pkg.sv | 13 +
 rtl/siphash_word_packer.sv | 39 +++
 rtl/siphash_msg_ctrl.sv | 110 +++++++++++
 tb/tb_siphash_msg_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/siphash_msg_ctrl_pkg.sv
// siphash_msg_ctrl_pkg: opcodes, controller states and pad-word helper shared by the message sequencer
package siphash_msg_ctrl_pkg;
  localparam logic [3:0] OP_KEY0  = 4'd0;
  localparam logic [3:0] OP_KEY1  = 4'd1;
  localparam logic [3:0] OP_COMP  = 4'd2;
  localparam logic [3:0] OP_FINAL = 4'd3;
  typedef enum logic [2:0] {
    S_IDLE, S_KEY0, S_KEY1, S_COLLECT, S_ISSUE_C, S_WAIT_C, S_ISSUE_F, S_WAIT_F
  } state_t;
  function automatic logic [63:0] pad_word(input logic [7:0] len8, input logic [63:0] word);
    return {len8, word[55:0]};
  endfunction
endpackage

// File: rtl/siphash_word_packer.sv
// siphash_word_packer: little-endian byte-to-word packing with byte count and pad-word build
module siphash_word_packer
  import siphash_msg_ctrl_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init,
  input  logic        clr,
  input  logic        wr,
  input  logic [7:0]  data,
  output logic [2:0]  idx,
  output logic [63:0] word_n,
  output logic [63:0] pad_n
);
  logic [63:0]      wbuf;
  logic [LEN_W-1:0] len, len_n;
  // word_n/pad_n already include the byte being accepted this cycle
  always_comb begin
    word_n = wr ? wbuf | ({56'h0, data} << {idx, 3'b000}) : wbuf;
    len_n  = len + {{(LEN_W-1){1'b0}}, wr};
    pad_n  = pad_word(len_n[7:0], word_n);
  end
  always_ff @(posedge clk) begin
    if (!rst_n || init) begin
      wbuf <= '0;
      idx  <= '0;
      len  <= '0;
    end else if (clr) begin
      wbuf <= '0;
      idx  <= '0;
    end else if (wr) begin
      wbuf <= word_n;
      idx  <= idx + 3'd1;
      len  <= len_n;
    end
  end
endmodule

// File: rtl/siphash_msg_ctrl.sv
// siphash_msg_ctrl: sequences key/compress/finalize commands to a siphash core from a byte stream
module siphash_msg_ctrl
  import siphash_msg_ctrl_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key,
  input  logic         in_valid,
  input  logic [7:0]   in_data,
  input  logic         in_last,
  input  logic         in_empty,
  output logic         in_ready,
  output logic         busy,
  output logic [63:0]  digest,
  output logic         digest_valid,
  output logic         core_we,
  output logic [67:0]  core_cmd,
  input  logic         core_busy,
  input  logic [63:0]  core_result
);
  state_t      state, state_n;
  logic        we_d, done, is_pad, is_pad_n, pend, pend_n;
  logic [67:0] cmd_d;
  logic [63:0] key_hi, word_n, pad_n;
  logic [2:0]  idx;
  logic        init, clr, byte_wr, full;
  assign in_ready = state == S_COLLECT;
  assign busy     = state != S_IDLE;
  assign init     = state == S_IDLE && start;
  assign clr      = state == S_ISSUE_C;
  assign byte_wr  = in_ready && in_valid && !(in_last && in_empty);
  assign full     = byte_wr && idx == 3'd7;
  siphash_word_packer #(.LEN_W(LEN_W)) u_packer (
    .clk(clk), .rst_n(rst_n), .init(init), .clr(clr), .wr(byte_wr), .data(in_data),
    .idx(idx), .word_n(word_n), .pad_n(pad_n)
  );
  // command registers are loaded on the transition so core_we is high in the ISSUE/KEY state itself
  always_comb begin
    state_n  = state;
    we_d     = 1'b0;
    cmd_d    = '0;
    done     = 1'b0;
    is_pad_n = is_pad;
    pend_n   = pend;
    case (state)
      S_IDLE: if (start) begin
        state_n = S_KEY0;
        we_d    = 1'b1;
        cmd_d   = {OP_KEY0, key[63:0]};
      end
      S_KEY0: begin
        state_n = S_KEY1;
        we_d    = 1'b1;
        cmd_d   = {OP_KEY1, key_hi};
      end
      S_KEY1: state_n = S_COLLECT;
      S_COLLECT: if (in_valid && (full || in_last)) begin
        state_n  = S_ISSUE_C;
        we_d     = 1'b1;
        cmd_d    = {OP_COMP, full ? word_n : pad_n};
        is_pad_n = !full;
        pend_n   = full && in_last;
      end
      S_ISSUE_C: state_n = S_WAIT_C;
      S_WAIT_C: if (!core_busy) begin
        if (is_pad) begin
          state_n = S_ISSUE_F;
          we_d    = 1'b1;
          cmd_d   = {OP_FINAL, 64'h0};
        end else if (pend) begin
          state_n  = S_ISSUE_C;
          we_d     = 1'b1;
          cmd_d    = {OP_COMP, pad_n};
          is_pad_n = 1'b1;
          pend_n   = 1'b0;
        end else state_n = S_COLLECT;
      end
      S_ISSUE_F: state_n = S_WAIT_F;
      S_WAIT_F: if (!core_busy) begin
        state_n = S_IDLE;
        done    = 1'b1;
      end
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      core_we      <= 1'b0;
      core_cmd     <= '0;
      key_hi       <= '0;
      is_pad       <= 1'b0;
      pend         <= 1'b0;
      digest       <= '0;
      digest_valid <= 1'b0;
    end else begin
      state        <= state_n;
      core_we      <= we_d;
      core_cmd     <= cmd_d;
      is_pad       <= is_pad_n;
      pend         <= pend_n;
      digest_valid <= done;
      if (init) key_hi <= key[127:64];
      if (done) digest <= core_result;
    end
  end
endmodule

// File: tb/tb_siphash_msg_ctrl.sv
// tb_siphash_msg_ctrl: controller plus a behavioural SipHash-2-4 core, scoreboarded commands and digests
module tb_siphash_msg_ctrl;
  typedef logic [3:0][63:0] st_t;
  logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [127:0] key = 128'h0f0e0d0c0b0a09080706050403020100;
  logic         in_valid = 1'b0, in_last = 1'b0, in_empty = 1'b0;
  logic [7:0]   in_data = 8'h0;
  logic         in_ready, busy, digest_valid, core_we;
  logic [63:0]  digest;
  logic [67:0]  core_cmd;
  logic         core_busy = 1'b0;
  logic [63:0]  core_result = 64'h0;
  int           errors = 0, checks = 0;
  logic [67:0]  exp_cmd[$];
  logic [63:0]  exp_dig[$];
  localparam logic [63:0] K0 = 64'h0706050403020100;
  localparam logic [63:0] K1 = 64'h0f0e0d0c0b0a0908;

  siphash_msg_ctrl #(.LEN_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key(key), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_empty(in_empty), .in_ready(in_ready), .busy(busy), .digest(digest),
    .digest_valid(digest_valid), .core_we(core_we), .core_cmd(core_cmd), .core_busy(core_busy),
    .core_result(core_result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected completion", name);
  endtask

  function automatic logic [63:0] rotl(input logic [63:0] x, input int r);
    return (x << r) | (x >> (64 - r));
  endfunction

  function automatic st_t sip(input st_t s, input int n);
    st_t v = s;
    for (int r = 0; r < n; r++) begin
      v[0] += v[1]; v[1] = rotl(v[1], 13); v[1] ^= v[0]; v[0] = rotl(v[0], 32);
      v[2] += v[3]; v[3] = rotl(v[3], 16); v[3] ^= v[2];
      v[0] += v[3]; v[3] = rotl(v[3], 21); v[3] ^= v[0];
      v[2] += v[1]; v[1] = rotl(v[1], 17); v[1] ^= v[2]; v[2] = rotl(v[2], 32);
    end
    return v;
  endfunction

  function automatic st_t comp(input st_t s, input logic [63:0] m);
    st_t v = s;
    v[3] ^= m;
    v = sip(v, 2);
    v[0] ^= m;
    return v;
  endfunction

  function automatic logic [63:0] fin(input st_t s);
    st_t v = s;
    v[2] ^= 64'hff;
    v = sip(v, 4);
    return v[0] ^ v[1] ^ v[2] ^ v[3];
  endfunction

  // behavioural core: busy for 3 cycles after COMP, 5 after FINAL
  st_t         v = '0;
  logic [63:0] k0 = 64'h0;
  int          cnt = 0;
  always @(posedge clk) begin
    if (!rst_n) begin
      core_busy <= 1'b0;
      cnt       <= 0;
    end else begin
      if (cnt > 0) begin
        cnt <= cnt - 1;
        if (cnt == 1) core_busy <= 1'b0;
      end
      if (core_we) case (core_cmd[67:64])
        4'd0: k0 <= core_cmd[63:0];
        4'd1: v <= {core_cmd[63:0] ^ 64'h7465646279746573, k0 ^ 64'h6c7967656e657261,
                    core_cmd[63:0] ^ 64'h646f72616e646f6d, k0 ^ 64'h736f6d6570736575};
        4'd2: begin
          v         <= comp(v, core_cmd[63:0]);
          core_busy <= 1'b1;
          cnt       <= 3;
        end
        4'd3: begin
          core_result <= fin(v);
          core_busy   <= 1'b1;
          cnt         <= 5;
        end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n && core_we) begin
      check("we_while_busy", {67'h0, core_busy}, 68'h0);
      if (exp_cmd.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL core_cmd: got %h expected none", core_cmd);
      end else check("core_cmd", core_cmd, exp_cmd.pop_front());
    end
    if (rst_n && digest_valid) begin
      if (exp_dig.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL digest: got %h expected none", digest);
      end else check("digest", {4'h0, digest}, {4'h0, exp_dig.pop_front()});
    end
  end

  task automatic push_key();
    exp_cmd.push_back({4'd0, K0});
    exp_cmd.push_back({4'd1, K1});
  endtask

  task automatic run_msg(input int n, input bit empty, input bit last, input bit rnd, input bit poke);
    int i = 0;
    int cyc = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (i < n && cyc < 2000) begin
      if (rnd && $urandom_range(0, 2) == 0) in_valid = 1'b0;
      else begin
        in_valid = 1'b1;
        in_data  = 8'(i);
        in_last  = last && i == n - 1;
        in_empty = empty;
      end
      start = poke && $urandom_range(0, 1) == 1;
      if (in_valid && in_ready) i++;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_empty = 1'b0;
    start    = 1'b0;
    if (cyc >= 2000) timeout("byte_accept");
    if (last) begin
      cyc = 0;
      while (busy && cyc < 500) begin
        start = poke && cyc < 3;
        @(negedge clk);
        cyc++;
      end
      start = 1'b0;
      if (cyc >= 500) timeout("digest_wait");
      @(negedge clk);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_in_ready", {67'h0, in_ready}, 68'h0);
    check("rst_busy", {67'h0, busy}, 68'h0);
    check("rst_digest", {4'h0, digest}, 68'h0);
    check("rst_digest_valid", {67'h0, digest_valid}, 68'h0);
    check("rst_core_we", {67'h0, core_we}, 68'h0);
    check("rst_core_cmd", core_cmd, 68'h0);
    rst_n = 1'b1;
    // empty message
    push_key();
    exp_cmd.push_back({4'd2, 64'h0});
    exp_cmd.push_back({4'd3, 64'h0});
    exp_dig.push_back(64'h726fdb47dd0e0e31);
    run_msg(1, 1'b1, 1'b1, 1'b0, 1'b0);
    // exactly one full word, pad carries only the length
    push_key();
    exp_cmd.push_back({4'd2, 64'h0706050403020100});
    exp_cmd.push_back({4'd2, 64'h0800000000000000});
    exp_cmd.push_back({4'd3, 64'h0});
    exp_dig.push_back(64'h93f5f5799a932462);
    run_msg(8, 1'b0, 1'b1, 1'b0, 1'b0);
    // 15 bytes: plain, gappy valid, start pokes
    for (int t = 0; t < 3; t++) begin
      push_key();
      exp_cmd.push_back({4'd2, 64'h0706050403020100});
      exp_cmd.push_back({4'd2, 64'h0f0e0d0c0b0a0908});
      exp_cmd.push_back({4'd3, 64'h0});
      exp_dig.push_back(64'ha129ca6149be45e5);
      run_msg(15, 1'b0, 1'b1, t == 1, t == 2);
    end
    // abandon a message while the core is compressing
    push_key();
    exp_cmd.push_back({4'd2, 64'h0706050403020100});
    run_msg(8, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 20 && !core_busy; c++) @(negedge clk);
    if (!core_busy) timeout("core_busy_wait");
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", {67'h0, busy}, 68'h0);
    check("post_rst_in_ready", {67'h0, in_ready}, 68'h0);
    check("post_rst_digest", {4'h0, digest}, 68'h0);
    push_key();
    exp_cmd.push_back({4'd2, 64'h0});
    exp_cmd.push_back({4'd3, 64'h0});
    exp_dig.push_back(64'h726fdb47dd0e0e31);
    run_msg(1, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("cmd_queue_left", 68'(exp_cmd.size()), 68'h0);
    check("digest_queue_left", 68'(exp_dig.size()), 68'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end
endmodule
